// File: rtl/imem_program_loader.sv
// Instruction-memory image writer: streams 32-bit words into the flat
// 8192-bit image and holds the core in reset until the image is complete.
module imem_program_loader #(
  parameter int NUM_WORDS = 256,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          wr_valid,
  input  logic [WORD_W-1:0]             wr_data,
  input  logic                          wr_last,
  output logic                          wr_ready,
  output logic [0:NUM_WORDS*WORD_W-1]   instructionMemory,
  output logic                          cpu_reset,
  output logic                          load_done,
  output logic [CNT_W-1:0]              word_count
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int IMG_W = NUM_WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [0:IMG_W-1]   img_q;
  logic [CNT_W-1:0]   count_q;
  logic [IDX_W-1:0]   slot;
  logic               last_slot;

  // In LOAD the count never exceeds NUM_WORDS-1, so its low bits index the slot.
  assign slot      = count_q[IDX_W-1:0];
  assign last_slot = (count_q == CNT_W'(NUM_WORDS - 1));

  // Load sequencer: owns state, image and word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      img_q   <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            img_q   <= '0;
            count_q <= '0;
          end
        end
        LOAD: begin
          if (wr_valid) begin
            img_q[slot*WORD_W +: WORD_W] <= wr_data;
            count_q <= count_q + CNT_W'(1);
            if (wr_last || last_slot) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_q <= LOAD;
            img_q   <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ready          = (state_q == LOAD);
  assign cpu_reset         = (state_q != DONE);
  assign load_done         = (state_q == DONE);
  assign instructionMemory = img_q;
  assign word_count        = count_q;

endmodule
